// File: rtl/aesl_dl_pkg.sv
// Purpose: shared types and constants for the deadlock report controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aesl_dl_pkg;

    // Controller FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_LAUNCH,
        ST_TRACE,
        ST_REPORT,
        ST_DONE
    } dl_state_t;

    // Default process count and the matching index width. Modules derive
    // their own width from their PROC_NUM parameter the same way.
    localparam int DL_PROC_NUM = 4;
    localparam int PROC_IDX_W  = $clog2(DL_PROC_NUM);

endpackage

// File: rtl/aesl_rr_pick.sv
// Purpose: round-robin first-set-bit finder, searching from ptr upward with wrap.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   req - request vector (N bits)
//   ptr - starting index for the search (must be < N)
//   idx - index of the first set bit at or after ptr, wrapping
//   hit - at least one request bit is set
module aesl_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         hit
);

    // Walk the offsets from the far end back to zero so the closest set
    // bit to ptr is the last (and therefore winning) assignment.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = W'((int'(ptr) + k) % N);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aesl_deadlock_report_ctrl.sv
// Purpose: pick a persistent deadlock candidate, launch and trace its token, report the cycle once.
// Latency: detect-to-origin pulse is SETTLE_CYCLES+2 cycles; return-to-report_valid is 1 cycle.
// Backpressure: report_valid and report_* hold until report_ready; nothing else is stalled.
//
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   dl_detect_vec       - per-unit deadlock detect flags
//   token_seen_vec      - per-unit token-forwarded flags (OR of token_out_vec)
//   token_return_vec    - per-unit token-received flags (OR of token_in_vec)
//   origin_vec          - one-hot launch pulse to the chosen unit
//   token_clear         - broadcast clear, high on the cycle a trace ends
//   report_valid/ready  - report handshake
//   report_origin/mask  - origin index and set of units visited by the token
//   deadlock_found      - sticky, set when the report is accepted
//   timeout_cnt         - saturating count of abandoned traces
//   busy                - controller is between IDLE and DONE
module aesl_deadlock_report_ctrl
    import aesl_dl_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [PROC_NUM-1:0]         dl_detect_vec,
    input  logic [PROC_NUM-1:0]         token_seen_vec,
    input  logic [PROC_NUM-1:0]         token_return_vec,
    output logic [PROC_NUM-1:0]         origin_vec,
    output logic                        token_clear,
    output logic                        report_valid,
    input  logic                        report_ready,
    output logic [$clog2(PROC_NUM)-1:0] report_origin,
    output logic [PROC_NUM-1:0]         report_mask,
    output logic                        deadlock_found,
    output logic [7:0]                  timeout_cnt,
    output logic                        busy
);

    localparam int IDX_W = $clog2(PROC_NUM);
    localparam int SW    = $clog2(SETTLE_CYCLES + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    dl_state_t            state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     cand;
    logic [SW-1:0]        settle_cnt;
    logic [TW-1:0]        trace_cnt;
    logic [PROC_NUM-1:0]  mask;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_hit;
    logic [IDX_W-1:0]     next_ptr;
    logic [PROC_NUM-1:0]  cand_onehot;
    logic                 cand_det;
    logic                 cand_ret;
    logic                 trace_timeout;

    aesl_rr_pick #(
        .N (PROC_NUM),
        .W (IDX_W)
    ) u_pick (
        .req (dl_detect_vec),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .hit (pick_hit)
    );

    assign next_ptr      = (cand == IDX_W'(PROC_NUM - 1)) ? '0 : cand + IDX_W'(1);
    assign cand_onehot   = {{(PROC_NUM-1){1'b0}}, 1'b1} << cand;
    assign cand_det      = dl_detect_vec[cand];
    assign cand_ret      = token_return_vec[cand];
    assign trace_timeout = (trace_cnt == TW'(TIMEOUT_CYCLES));

    // Clear fires on the trace exit cycle only; gated by reset so a reset
    // that lands mid-trace never leaks a clear to the units.
    assign token_clear = !reset && (state == ST_TRACE) && (cand_ret || trace_timeout);
    assign busy        = (state != ST_IDLE) && (state != ST_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            cand           <= '0;
            settle_cnt     <= '0;
            trace_cnt      <= '0;
            mask           <= '0;
            origin_vec     <= '0;
            report_valid   <= 1'b0;
            report_origin  <= '0;
            report_mask    <= '0;
            deadlock_found <= 1'b0;
            timeout_cnt    <= '0;
        end else begin
            // Launch pulse lasts exactly the LAUNCH state.
            origin_vec <= '0;

            case (state)
                ST_IDLE: begin
                    if (pick_hit) begin
                        cand       <= pick_idx;
                        settle_cnt <= '0;
                        state      <= ST_CONFIRM;
                    end
                end

                ST_CONFIRM: begin
                    if (!cand_det) begin
                        // Transient detect: move past this unit so a
                        // flickering low index cannot starve the others.
                        rr_ptr <= next_ptr;
                        state  <= ST_IDLE;
                    end else if (settle_cnt == SW'(SETTLE_CYCLES)) begin
                        origin_vec <= cand_onehot;
                        state      <= ST_LAUNCH;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end

                ST_LAUNCH: begin
                    mask      <= cand_onehot;
                    trace_cnt <= '0;
                    state     <= ST_TRACE;
                end

                ST_TRACE: begin
                    mask      <= mask | token_seen_vec;
                    trace_cnt <= trace_cnt + TW'(1);
                    if (cand_ret) begin
                        // Return beats a coincident timeout. Fold in this
                        // cycle's sightings so the report is complete.
                        report_valid  <= 1'b1;
                        report_origin <= cand;
                        report_mask   <= mask | token_seen_vec;
                        state         <= ST_REPORT;
                    end else if (trace_timeout) begin
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                        rr_ptr <= next_ptr;
                        state  <= ST_IDLE;
                    end
                end

                ST_REPORT: begin
                    if (report_ready) begin
                        report_valid   <= 1'b0;
                        deadlock_found <= 1'b1;
                        state          <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Terminal until reset; report_origin/mask keep their values.
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aesl_deadlock_report_ctrl.sv
module tb_aesl_deadlock_report_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] dl_detect_vec;
    logic [3:0] token_seen_vec;
    logic [3:0] token_return_vec;
    logic [3:0] origin_vec;
    logic       token_clear;
    logic       report_valid;
    logic       report_ready;
    logic [1:0] report_origin;
    logic [3:0] report_mask;
    logic       deadlock_found;
    logic [7:0] timeout_cnt;
    logic       busy;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    aesl_deadlock_report_ctrl #(
        .PROC_NUM       (4),
        .SETTLE_CYCLES  (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .dl_detect_vec    (dl_detect_vec),
        .token_seen_vec   (token_seen_vec),
        .token_return_vec (token_return_vec),
        .origin_vec       (origin_vec),
        .token_clear      (token_clear),
        .report_valid     (report_valid),
        .report_ready     (report_ready),
        .report_origin    (report_origin),
        .report_mask      (report_mask),
        .deadlock_found   (deadlock_found),
        .timeout_cnt      (timeout_cnt),
        .busy             (busy)
    );

    typedef struct {
        logic [3:0] det;
        logic [3:0] seen;
        logic [3:0] ret;
        logic       rdy;
        logic [3:0] e_org;
        logic       e_tclr;
        logic       e_vld;
        logic [1:0] e_rorg;
        logic [3:0] e_rmask;
        logic       e_found;
        logic       e_busy;
    } vec_t;

    localparam int NROWS = 18;
    vec_t tbl [NROWS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic row(input int i, input logic [3:0] det, input logic [3:0] seen,
                       input logic [3:0] ret, input logic rdy, input logic [3:0] org,
                       input logic tclr, input logic vld, input logic [1:0] rorg,
                       input logic [3:0] rmask, input logic found, input logic bsy);
        tbl[i].det     = det;
        tbl[i].seen    = seen;
        tbl[i].ret     = ret;
        tbl[i].rdy     = rdy;
        tbl[i].e_org   = org;
        tbl[i].e_tclr  = tclr;
        tbl[i].e_vld   = vld;
        tbl[i].e_rorg  = rorg;
        tbl[i].e_rmask = rmask;
        tbl[i].e_found = found;
        tbl[i].e_busy  = bsy;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        dl_detect_vec    = '0;
        token_seen_vec   = '0;
        token_return_vec = '0;
        report_ready     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_origin_vec"}, 32'(origin_vec), 0);
        chk({tag, "_token_clear"}, 32'(token_clear), 0);
        chk({tag, "_report_valid"}, 32'(report_valid), 0);
        chk({tag, "_report_origin"}, 32'(report_origin), 0);
        chk({tag, "_report_mask"}, 32'(report_mask), 0);
        chk({tag, "_deadlock_found"}, 32'(deadlock_found), 0);
        chk({tag, "_timeout_cnt"}, 32'(timeout_cnt), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // From IDLE: hold det, expect no launch for 10 cycles, then exp one-hot.
    task automatic launch(input logic [3:0] det, input logic [3:0] exp, input string tag);
        int bad;
        bad = 0;
        dl_detect_vec = det;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (origin_vec != 4'b0) bad++;
            tick();
        end
        chk({tag, "_launch_early"}, 32'(bad), 0);
        chk({tag, "_launch_vec"}, 32'(origin_vec), 32'(exp));
    endtask

    initial begin
        int bad;
        int cyc;
        int launches;

        // Reset state
        do_reset();
        check_reset_outputs("rst0");

        // Main launch/trace/report scenario, cycle by cycle
        row(0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++)
            row(i, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
        row(10, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
        row(11, 4'b0100, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
        row(12, 4'b0100, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
        row(13, 4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
        row(14, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b1101, 1'b0, 1'b1);
        row(15, 4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b1101, 1'b0, 1'b1);
        row(16, 4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b1101, 1'b1, 1'b0);
        row(17, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b1101, 1'b1, 1'b0);

        for (int i = 0; i < NROWS; i++) begin
            dl_detect_vec    = tbl[i].det;
            token_seen_vec   = tbl[i].seen;
            token_return_vec = tbl[i].ret;
            report_ready     = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_origin_vec", i), 32'(origin_vec), 32'(tbl[i].e_org));
            chk($sformatf("vec%0d_token_clear", i), 32'(token_clear), 32'(tbl[i].e_tclr));
            chk($sformatf("vec%0d_report_valid", i), 32'(report_valid), 32'(tbl[i].e_vld));
            chk($sformatf("vec%0d_report_origin", i), 32'(report_origin), 32'(tbl[i].e_rorg));
            chk($sformatf("vec%0d_report_mask", i), 32'(report_mask), 32'(tbl[i].e_rmask));
            chk($sformatf("vec%0d_deadlock_found", i), 32'(deadlock_found), 32'(tbl[i].e_found));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            tick();
        end

        // Confirm abort moves the pointer past the dropped candidate
        do_reset();
        dl_detect_vec = 4'b0010;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (origin_vec != 4'b0) bad++;
            tick();
        end
        dl_detect_vec = 4'b0000;
        tick();
        chk("abort_no_launch", 32'(bad), 0);
        chk("abort_idle", 32'(busy), 0);
        launch(4'b0011, 4'b0001, "wrap");

        // Timeout, then a return coinciding with the timeout
        do_reset();
        launch(4'b0001, 4'b0001, "to");
        tick();
        bad = 0;
        for (int t = 0; t < 64; t++) begin
            #1;
            if (token_clear) bad++;
            tick();
        end
        chk("timeout_clear_early", 32'(bad), 0);
        #1;
        chk("timeout_clear", 32'(token_clear), 1);
        tick();
        chk("timeout_idle", 32'(busy), 0);
        chk("timeout_cnt1", 32'(timeout_cnt), 1);
        chk("timeout_no_report", 32'(report_valid), 0);

        launch(4'b0001, 4'b0001, "both");
        tick();
        repeat (64) tick();
        token_return_vec = 4'b0001;
        #1;
        chk("both_clear", 32'(token_clear), 1);
        tick();
        token_return_vec = 4'b0000;
        chk("both_report_valid", 32'(report_valid), 1);
        chk("both_report_origin", 32'(report_origin), 0);
        chk("both_report_mask", 32'(report_mask), 32'h1);
        chk("both_timeout_cnt", 32'(timeout_cnt), 1);

        // Report held under backpressure, then accepted; DONE ignores detects
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (report_valid !== 1'b1 || report_origin !== 2'd0 || report_mask !== 4'b0001) bad++;
        end
        chk("stall_stable", 32'(bad), 0);
        report_ready = 1'b1;
        tick();
        report_ready = 1'b0;
        chk("accept_found", 32'(deadlock_found), 1);
        chk("accept_valid_low", 32'(report_valid), 0);
        chk("accept_done", 32'(busy), 0);
        dl_detect_vec = 4'b1111;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy || origin_vec != 4'b0 || report_valid) bad++;
        end
        chk("done_ignores", 32'(bad), 0);
        chk("done_mask_hold", 32'(report_mask), 32'h1);

        // Repeated timeouts: round-robin order and saturation of timeout_cnt
        do_reset();
        dl_detect_vec = 4'b1111;
        launches = 0;
        cyc = 0;
        bad = 0;
        while (timeout_cnt != 8'hFF && cyc < 30000) begin
            tick();
            cyc++;
            if (report_valid) bad++;
            if (origin_vec != 4'b0 && launches < 4) begin
                chk($sformatf("rr_order%0d", launches), 32'(origin_vec), 32'(1 << launches));
                launches++;
            end
        end
        chk("rr_launches", 32'(launches), 4);
        chk("sat_no_report", 32'(bad), 0);
        chk("sat_reached", 32'(timeout_cnt), 255);
        repeat (300) tick();
        chk("sat_hold", 32'(timeout_cnt), 255);

        // Reset during TRACE
        cyc = 0;
        while (origin_vec == 4'b0 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("rstT_launch_seen", 32'(origin_vec != 4'b0), 1);
        tick();
        reset = 1'b1;
        token_return_vec = 4'b1111;
        #1;
        chk("rstT_no_clear", 32'(token_clear), 0);
        tick();
        reset = 1'b0;
        token_return_vec = 4'b0000;
        dl_detect_vec = 4'b0000;
        check_reset_outputs("rstT");

        // Reset during REPORT
        launch(4'b1000, 4'b1000, "rstR");
        tick();
        token_seen_vec = 4'b0010;
        tick();
        token_seen_vec = 4'b0000;
        token_return_vec = 4'b1000;
        tick();
        token_return_vec = 4'b0000;
        chk("rstR_report_valid", 32'(report_valid), 1);
        chk("rstR_report_origin", 32'(report_origin), 3);
        chk("rstR_report_mask", 32'(report_mask), 32'hA);
        reset = 1'b1;
        #1;
        chk("rstR_no_clear", 32'(token_clear), 0);
        tick();
        reset = 1'b0;
        dl_detect_vec = 4'b0000;
        check_reset_outputs("rstR");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
